// File: rtl/bitonic_sort8_seq_pkg.sv
// bitonic_sort8_seq_pkg: shared width, state encoding and 8-key bitonic stage schedule.
package bitonic_sort8_seq_pkg;
    localparam int WIDTH_DEF = 8;
    typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;
    // Entry 0 is the first stage applied: (k,j) = (2,1),(4,2),(4,1),(8,4),(8,2),(8,1).
    localparam logic [5:0][3:0] K_TAB = {4'd8, 4'd8, 4'd8, 4'd4, 4'd4, 4'd2};
    localparam logic [5:0][2:0] J_TAB = {3'd1, 3'd2, 3'd4, 3'd1, 3'd2, 3'd1};
    // Lower index of pair u: u with a zero bit inserted at the position of j.
    function automatic logic [2:0] pair_lo(input logic [1:0] u, input logic [2:0] j);
        return j[0] ? {u, 1'b0} : j[1] ? {u[1], 1'b0, u[0]} : {1'b0, u};
    endfunction
endpackage

// File: rtl/bitonic_sort8_seq_cas.sv
// bitonic_cas: directional compare-exchange; equal keys pass through unswapped.
module bitonic_cas #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             up,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);
    logic swap;
    assign swap = up ? (a > b) : (a < b);
    assign lo = swap ? b : a;
    assign hi = swap ? a : b;
endmodule

// File: rtl/bitonic_sort8_seq.sv
// bitonic_sort8_seq: serial-in 8-key bitonic sorter, one network stage per clock, serial out.
module bitonic_sort8_seq
    import bitonic_sort8_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_desc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);
    state_t state;
    logic [WIDTH-1:0] key_buf [8];
    logic [2:0] cnt, idx, stage, j;
    logic [3:0] k;
    logic desc;
    logic [2:0] lo_i [4];
    logic [2:0] hi_i [4];
    logic [WIDTH-1:0] lo [4];
    logic [WIDTH-1:0] hi [4];

    assign j = J_TAB[stage];
    assign k = K_TAB[stage];
    assign out_data = key_buf[idx];

    for (genvar g = 0; g < 4; g++) begin : g_cas
        assign lo_i[g] = pair_lo(2'(g), j);
        assign hi_i[g] = lo_i[g] ^ j;
        bitonic_cas #(.WIDTH(WIDTH)) u_cas (
            .a  (key_buf[lo_i[g]]),
            .b  (key_buf[hi_i[g]]),
            .up ((({1'b0, lo_i[g]} & k) == 4'd0) ^ desc),
            .lo (lo[g]),
            .hi (hi[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= LOAD;
            cnt       <= '0;
            idx       <= '0;
            stage     <= '0;
            desc      <= 1'b0;
            key_buf   <= '{default: '0};
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                LOAD: if (in_valid) begin
                    key_buf[cnt] <= in_data;
                    cnt          <= cnt + 3'd1;
                    if (cnt == 3'd0) desc <= in_desc;
                    if (cnt == 3'd7) begin
                        stage    <= '0;
                        state    <= SORT;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                SORT: begin
                    for (int u = 0; u < 4; u++) begin
                        key_buf[lo_i[u]] <= lo[u];
                        key_buf[hi_i[u]] <= hi[u];
                    end
                    stage <= (stage == 3'd5) ? 3'd0 : stage + 3'd1;
                    if (stage == 3'd5) begin
                        state     <= OUT;
                        idx       <= '0;
                        out_valid <= 1'b1;
                    end
                end
                default: if (out_ready) begin
                    idx <= idx + 3'd1;
                    if (idx == 3'd7) begin
                        state     <= LOAD;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule
